// File: rtl/mem_store_writer_pkg.sv
// Shared types and sizes for the matrix store writer: float_sp, matrix size widths,
// the writer FSM state type and the default external address width.
package mem_store_writer_pkg;

  localparam int MBITS           = 3;
  localparam int NBITS           = 3;
  localparam int MATRIX_REG_BITS = 3;
  localparam int ADDR_W_DEFAULT  = 16;
  // Wide enough for M*N with M,N up to 2^MBITS and 2^NBITS.
  localparam int TOTAL_W         = MBITS + NBITS + 2;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float_sp;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_COLLECT,
    ST_DRAIN,
    ST_DONE
  } mem_store_state_e;

  function automatic logic is_nan(input float_sp v);
    return (v.exponent == 8'hFF) && (v.mantissa != 23'd0);
  endfunction

endpackage

// File: rtl/mem_store_fifo.sv
// Synchronous element FIFO, power-of-two depth; a push into a full FIFO is
// accepted when a pop happens in the same cycle. Head is read from registered storage.
module mem_store_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_store_writer.sv
// Collects the store unit's row-major element stream into a FIFO and writes it to
// memory at base + element index. Optional NaN detection under MEM_STORE_NAN_CHECK_EN.
module mem_store_writer
  import mem_store_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = ADDR_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid_in,
  input  logic [MATRIX_REG_BITS:0]   cmd_reg_addr_in,
  input  logic [ADDR_W-1:0]          cmd_base_addr_in,
  output logic                       cmd_ready_out,
  output logic                       store_req_out,
  output logic [MATRIX_REG_BITS:0]   mem_store_addr_out,
  input  logic                       mem_store_en_in,
  input  logic [MBITS:0]             mem_m_store_size_in,
  input  logic [NBITS:0]             mem_n_store_size_in,
  input  float_sp                    mem_store_element_in,
  output logic                       mem_wr_en_out,
  output logic [ADDR_W-1:0]          mem_wr_addr_out,
  output float_sp                    mem_wr_data_out,
  input  logic                       mem_wr_ready_in,
  output logic                       done_out,
  output logic                       overflow_err_out,
  output logic                       size_err_out,
`ifdef MEM_STORE_NAN_CHECK_EN
  output logic                       nan_err_out,
`endif
  output mem_store_state_e           state_dbg_out
);

  // Each FIFO entry carries its element index so dropped elements leave an address gap.
  localparam int FW = TOTAL_W + 32;

  mem_store_state_e   state;
  logic [ADDR_W-1:0]  base_q;
  logic [TOTAL_W-1:0] total_q;
  logic [TOTAL_W-1:0] rx_cnt;
  logic               total_valid;

  logic               fifo_full;
  logic               fifo_empty;
  logic [FW-1:0]      fifo_head;
  logic [TOTAL_W-1:0] head_idx;
  float_sp            head_data;

  logic [TOTAL_W-1:0] total_now;
  logic               size_zero;
  logic               push;
  logic               push_ok;
  logic               wr_active;
  logic               pop;

  assign total_now = total_valid ? total_q
                                 : TOTAL_W'(mem_m_store_size_in) * TOTAL_W'(mem_n_store_size_in);
  assign size_zero = !total_valid &&
                     ((mem_m_store_size_in == '0) || (mem_n_store_size_in == '0));
  assign push      = (state == ST_COLLECT) && mem_store_en_in && !size_zero;
  assign wr_active = ((state == ST_COLLECT) || (state == ST_DRAIN)) && !fifo_empty;

  // Memory write handshake: an element transfers on a cycle with mem_wr_en_out && mem_wr_ready_in;
  // while mem_wr_en_out && !mem_wr_ready_in the address and data are held unchanged.
  assign pop       = wr_active && mem_wr_ready_in;
  assign push_ok   = push && (!fifo_full || pop);

  assign {head_idx, head_data} = fifo_head;

  mem_store_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({rx_cnt, mem_store_element_in}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_IDLE;
      mem_store_addr_out <= '0;
      base_q             <= '0;
      total_q            <= '0;
      rx_cnt             <= '0;
      total_valid        <= 1'b0;
      overflow_err_out   <= 1'b0;
      size_err_out       <= 1'b0;
`ifdef MEM_STORE_NAN_CHECK_EN
      nan_err_out        <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid_in) begin
            mem_store_addr_out <= cmd_reg_addr_in;
            base_q             <= cmd_base_addr_in;
            total_q            <= '0;
            rx_cnt             <= '0;
            total_valid        <= 1'b0;
            overflow_err_out   <= 1'b0;
            size_err_out       <= 1'b0;
`ifdef MEM_STORE_NAN_CHECK_EN
            nan_err_out        <= 1'b0;
`endif
            state              <= ST_REQUEST;
          end
        end
        ST_REQUEST: state <= ST_COLLECT;
        ST_COLLECT: begin
          if (mem_store_en_in) begin
            if (size_zero) begin
              size_err_out <= 1'b1;
              state        <= ST_DONE;
            end else begin
              total_valid <= 1'b1;
              total_q     <= total_now;
              rx_cnt      <= rx_cnt + TOTAL_W'(1);
              if (!push_ok) overflow_err_out <= 1'b1;
`ifdef MEM_STORE_NAN_CHECK_EN
              if (push_ok && is_nan(mem_store_element_in)) nan_err_out <= 1'b1;
`endif
              if (rx_cnt + TOTAL_W'(1) == total_now) state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: if (fifo_empty) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_out   = (state == ST_IDLE);
  assign store_req_out   = (state == ST_REQUEST);
  assign done_out        = (state == ST_DONE);
  assign state_dbg_out   = state;
  assign mem_wr_en_out   = wr_active;
  assign mem_wr_addr_out = wr_active ? (base_q + ADDR_W'(head_idx)) : '0;
  assign mem_wr_data_out = wr_active ? head_data : '0;

endmodule

// File: tb/tb_mem_store_writer.sv
// Randomized bench for mem_store_writer against a queue model of expected writes.
// Define MEM_STORE_NAN_CHECK_EN to also check the NaN flag.
module tb_mem_store_writer;
  import mem_store_writer_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int EW    = AW + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                     cmd_valid_in;
  logic [MATRIX_REG_BITS:0] cmd_reg_addr_in;
  logic [AW-1:0]            cmd_base_addr_in;
  logic                     cmd_ready_out;
  logic                     store_req_out;
  logic [MATRIX_REG_BITS:0] mem_store_addr_out;
  logic                     mem_store_en_in;
  logic [MBITS:0]           mem_m_store_size_in;
  logic [NBITS:0]           mem_n_store_size_in;
  logic [31:0]              mem_store_element_in;
  logic                     mem_wr_en_out;
  logic [AW-1:0]            mem_wr_addr_out;
  logic [31:0]              mem_wr_data_out;
  logic                     mem_wr_ready_in;
  logic                     done_out;
  logic                     overflow_err_out;
  logic                     size_err_out;
  mem_store_state_e         state_dbg;
`ifdef MEM_STORE_NAN_CHECK_EN
  logic                     nan_err_out;
`endif

  mem_store_writer #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cmd_valid_in         (cmd_valid_in),
    .cmd_reg_addr_in      (cmd_reg_addr_in),
    .cmd_base_addr_in     (cmd_base_addr_in),
    .cmd_ready_out        (cmd_ready_out),
    .store_req_out        (store_req_out),
    .mem_store_addr_out   (mem_store_addr_out),
    .mem_store_en_in      (mem_store_en_in),
    .mem_m_store_size_in  (mem_m_store_size_in),
    .mem_n_store_size_in  (mem_n_store_size_in),
    .mem_store_element_in (mem_store_element_in),
    .mem_wr_en_out        (mem_wr_en_out),
    .mem_wr_addr_out      (mem_wr_addr_out),
    .mem_wr_data_out      (mem_wr_data_out),
    .mem_wr_ready_in      (mem_wr_ready_in),
    .done_out             (done_out),
    .overflow_err_out     (overflow_err_out),
    .size_err_out         (size_err_out),
`ifdef MEM_STORE_NAN_CHECK_EN
    .nan_err_out          (nan_err_out),
`endif
    .state_dbg_out        (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  // Buffered writes still owed to memory, oldest first: {address, data}.
  logic [EW-1:0] exp_q[$];
  logic          exp_ovf;
  logic          exp_nan;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit elem_is_nan(input logic [31:0] e);
    return (e[30:23] == 8'hFF) && (e[22:0] != 23'd0);
  endfunction

  // ---------------- driver tasks ----------------
  // ready_mode: 0 always high, 1 low for the first 10 cycles, 2 toggling, 3 random.
  task automatic run_xfer(input int m, input int n, input logic [AW-1:0] base,
                          input int ready_mode, input int en_pct, input logic [31:0] first_elem);
    int                       stream_len;
    int                       sent;
    int                       done_cnt;
    bit                       finished;
    bit                       size_case;
    bit                       rdy;
    logic [31:0]              elem;
    logic [MATRIX_REG_BITS:0] reg_sel;

    size_case  = (m == 0) || (n == 0);
    stream_len = size_case ? 1 : m * n;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_nan = 1'b0;

    @(negedge clk);
    check("cmd_ready_idle", cmd_ready_out, 1);
    reg_sel             = (MATRIX_REG_BITS+1)'($urandom_range(0, 15));
    cmd_valid_in        = 1'b1;
    cmd_reg_addr_in     = reg_sel;
    cmd_base_addr_in    = base;
    mem_m_store_size_in = (MBITS+1)'(m);
    mem_n_store_size_in = (NBITS+1)'(n);
    @(negedge clk);
    cmd_valid_in = 1'b0;
    check("store_req_high", store_req_out, 1);
    check("cmd_ready_busy", cmd_ready_out, 0);
    check("reg_select", mem_store_addr_out, reg_sel);

    sent     = 0;
    done_cnt = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 0) check("store_req_one_cycle", store_req_out, 0);
      if (done_out) begin
        done_cnt++;
        finished = 1'b1;
        check("done_after_drain", (exp_q.size() == 0) && (sent == stream_len), 1);
      end
      check("wr_en", mem_wr_en_out, exp_q.size() > 0);
      if (mem_wr_en_out && exp_q.size() > 0)
        check("wr_addr_data", {mem_wr_addr_out, mem_wr_data_out}, exp_q[0]);

      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc >= 10);
        2:       rdy = (cyc % 2 == 0);
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      mem_wr_ready_in = rdy;
      if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());

      if (!finished && sent < stream_len && $urandom_range(0, 99) < en_pct) begin
        elem                 = (sent == 0) ? first_elem : $urandom;
        mem_store_en_in      = 1'b1;
        mem_store_element_in = elem;
        if (!size_case) begin
          if (exp_q.size() < DEPTH) begin
            exp_q.push_back({base + AW'(sent), elem});
            if (elem_is_nan(elem)) exp_nan = 1'b1;
          end else begin
            exp_ovf = 1'b1;
          end
        end
        sent++;
      end else begin
        mem_store_en_in = 1'b0;
      end
    end
    mem_store_en_in = 1'b0;
    check("done_seen", finished, 1);

    @(negedge clk);
    check("done_one_cycle", done_out, 0);
    check("back_to_idle", cmd_ready_out, 1);
    check("overflow_flag", overflow_err_out, exp_ovf);
    check("size_flag", size_err_out, size_case);
`ifdef MEM_STORE_NAN_CHECK_EN
    check("nan_flag", nan_err_out, exp_nan);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"},     state_dbg, ST_IDLE);
    check({tag, "_wr_en"},     mem_wr_en_out, 0);
    check({tag, "_wr_addr"},   mem_wr_addr_out, 0);
    check({tag, "_wr_data"},   mem_wr_data_out, 0);
    check({tag, "_store_req"}, store_req_out, 0);
    check({tag, "_reg_sel"},   mem_store_addr_out, 0);
    check({tag, "_done"},      done_out, 0);
    check({tag, "_ovf"},       overflow_err_out, 0);
    check({tag, "_size"},      size_err_out, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst                  = 1'b1;
    cmd_valid_in         = 1'b0;
    cmd_reg_addr_in      = '0;
    cmd_base_addr_in     = '0;
    mem_store_en_in      = 1'b0;
    mem_m_store_size_in  = '0;
    mem_n_store_size_in  = '0;
    mem_store_element_in = '0;
    mem_wr_ready_in      = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    run_xfer(2, 3, 16'h0100, 0, 100, $urandom);
    run_xfer(3, 3, 16'h0000, 1, 100, $urandom);
    run_xfer(2, 2, 16'h0200, 2, 100, $urandom);
    run_xfer(2, 2, 16'hFFFE, 0, 100, $urandom);
    run_xfer(0, 3, 16'h0500, 0, 100, $urandom);
    run_xfer(2, 0, 16'h0600, 3, 100, $urandom);

    // Reset in the middle of collecting a 4x4 with writes stalled.
    @(negedge clk);
    cmd_valid_in        = 1'b1;
    cmd_reg_addr_in     = 4'hA;
    cmd_base_addr_in    = 16'h0400;
    mem_m_store_size_in = 4'd4;
    mem_n_store_size_in = 4'd4;
    @(negedge clk);
    cmd_valid_in    = 1'b0;
    mem_wr_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_store_en_in      = 1'b1;
      mem_store_element_in = $urandom;
    end
    @(negedge clk);
    check("pre_rst_wr_en", mem_wr_en_out, 1);
    mem_store_en_in = 1'b0;
    rst             = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    rst             = 1'b0;
    mem_wr_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_write_after_rst", mem_wr_en_out, 0);
    end
    run_xfer(4, 4, 16'h0700, 3, 80, $urandom);

    run_xfer(1, 2, 16'h0300, 0, 100, 32'h7FC00000);

    for (int t = 0; t < 12; t++)
      run_xfer($urandom_range(1, 5), $urandom_range(1, 5), AW'($urandom),
               3, $urandom_range(40, 100), $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
